// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: baud divisor table, parity modes, rx FSM states.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  function automatic int unsigned baud_rate(input int unsigned sel);
    case (sel)
      0:       return 300;
      1:       return 1200;
      2:       return 4800;
      3:       return 9600;
      4:       return 19200;
      5:       return 38400;
      6:       return 57600;
      default: return 115200;
    endcase
  endfunction

  // Clamped to 1 so a slow system clock never yields a zero divisor.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned oversample,
                                           input int unsigned sel);
    int unsigned d;
    d = clk_hz / (baud_rate(sel) * oversample);
    if (d == 0) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO with valid/ready pop and sticky overrun on dropped pushes.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overrun;
  logic             w_full;
  logic             w_pop;
  logic             w_wr;

  assign w_full = (r_count == (AW+1)'(DEPTH));
  assign w_pop  = (r_count != '0) && i_pop_ready;
  // A pop in the same cycle frees the slot the incoming word needs.
  assign w_wr   = i_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_push && !w_wr) r_overrun <= 1'b1;
      else if (w_pop)      r_overrun <= 1'b0;
    end
  end

  assign o_data    = r_mem[r_rd_ptr];
  assign o_valid   = (r_count != '0);
  assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, preset to a reset level.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_q    <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled majority-vote framing feeding a show-ahead FIFO.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           baud_select,
  input  logic                 RxD,
  input  logic                 Rx_EN,
  input  logic                 Rx_READY,
  output logic [DATA_BITS-1:0] Rx_DATA,
  output logic                 Rx_PERROR,
  output logic                 Rx_FERROR,
  output logic                 Rx_VALID,
  output logic                 Rx_OVERRUN
);

  localparam int unsigned   SW       = $clog2(OVERSAMPLE);
  localparam int unsigned   WW       = DATA_BITS + 2;
  localparam logic [SW-1:0] VOTE_IDX = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] LAST_IDX = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

  rx_state_e            r_state, w_next;
  logic                 w_rx;
  logic [31:0]          w_div_sel, r_div, r_div_cnt;
  logic                 w_tick, w_vote_tick, w_bit_end, w_vote, w_last_stop, w_par_exp;
  logic [SW-1:0]        r_smp_cnt;
  logic [1:0]           r_smp;
  logic [3:0]           r_bit_cnt;
  logic                 r_stop_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perror, r_ferror, r_push;
  logic [WW-1:0]        r_push_word, w_head;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(reset),
    .i_d  (RxD),
    .o_q  (w_rx)
  );

  always_comb begin
    w_div_sel = '0;
    case (baud_select)
      3'd0: w_div_sel = baud_div(CLK_HZ, OVERSAMPLE, 0);
      3'd1: w_div_sel = baud_div(CLK_HZ, OVERSAMPLE, 1);
      3'd2: w_div_sel = baud_div(CLK_HZ, OVERSAMPLE, 2);
      3'd3: w_div_sel = baud_div(CLK_HZ, OVERSAMPLE, 3);
      3'd4: w_div_sel = baud_div(CLK_HZ, OVERSAMPLE, 4);
      3'd5: w_div_sel = baud_div(CLK_HZ, OVERSAMPLE, 5);
      3'd6: w_div_sel = baud_div(CLK_HZ, OVERSAMPLE, 6);
      3'd7: w_div_sel = baud_div(CLK_HZ, OVERSAMPLE, 7);
    endcase
  end

  // Vote uses the two previously stored samples plus the one taken on this tick.
  assign w_tick      = (r_div_cnt == r_div - 32'd1);
  assign w_vote_tick = w_tick && (r_smp_cnt == VOTE_IDX);
  assign w_bit_end   = w_tick && (r_smp_cnt == LAST_IDX);
  assign w_vote      = (r_smp[1] & r_smp[0]) | (r_smp[1] & w_rx) | (r_smp[0] & w_rx);
  assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : r_stop_cnt;
  assign w_par_exp   = (PARITY_MODE == PAR_ODD) ? ~(^r_shift) : (^r_shift);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!Rx_EN) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:      if (!w_rx) w_next = ST_START;
        ST_START: begin
          if (w_vote_tick && w_vote) w_next = ST_IDLE;
          else if (w_bit_end)        w_next = ST_DATA;
        end
        ST_DATA: begin
          if (w_bit_end && (r_bit_cnt == LAST_BIT))
            w_next = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
        ST_PARITY:    if (w_bit_end) w_next = ST_STOP;
        ST_STOP: begin
          if (w_vote_tick && w_last_stop) w_next = w_vote ? ST_IDLE : ST_WAIT_HIGH;
        end
        ST_WAIT_HIGH: if (w_rx) w_next = ST_IDLE;
        default:      w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div       <= '0;
      r_div_cnt   <= '0;
      r_smp_cnt   <= '0;
      r_smp       <= '1;
      r_bit_cnt   <= '0;
      r_stop_cnt  <= 1'b0;
      r_shift     <= '0;
      r_perror    <= 1'b0;
      r_ferror    <= 1'b0;
      r_push      <= 1'b0;
      r_push_word <= '0;
    end else begin
      r_push <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_div_cnt  <= '0;
        r_smp_cnt  <= '0;
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
        r_perror   <= 1'b0;
        r_ferror   <= 1'b0;
        if (w_next == ST_START) r_div <= w_div_sel;
      end else begin
        if (w_tick) begin
          r_div_cnt <= '0;
          r_smp_cnt <= r_smp_cnt + 1'b1;
          r_smp     <= {r_smp[0], w_rx};
        end else begin
          r_div_cnt <= r_div_cnt + 32'd1;
        end
        if (r_state == ST_DATA) begin
          if (w_vote_tick) r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
          if (w_bit_end)   r_bit_cnt <= r_bit_cnt + 4'd1;
        end
        if (r_state == ST_PARITY && w_vote_tick) r_perror <= (w_vote != w_par_exp);
        if (r_state == ST_STOP) begin
          if (w_vote_tick && !w_vote) r_ferror <= 1'b1;
          if (w_vote_tick && w_last_stop && Rx_EN) begin
            r_push      <= 1'b1;
            r_push_word <= {r_shift, r_perror, r_ferror | ~w_vote};
          end
          if (w_bit_end) r_stop_cnt <= 1'b1;
        end
      end
    end
  end

  uart_rx_fifo #(.WIDTH(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .i_push     (r_push),
    .i_push_data(r_push_word),
    .i_pop_ready(Rx_READY),
    .o_data     (w_head),
    .o_valid    (Rx_VALID),
    .o_overrun  (Rx_OVERRUN)
  );

  assign Rx_DATA   = w_head[WW-1:2];
  assign Rx_PERROR = w_head[1];
  assign Rx_FERROR = w_head[0];

endmodule
